// File: rtl/spi_regif_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_regif_if
//  Description : Register-file access bus between the SPI slave bridge
//                (master side) and the internal register file (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_regif_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] reg_addr_o;
    logic [DATA_W-1:0] reg_wdata_o;
    logic              reg_we_o;
    logic              reg_re_o;
    logic [DATA_W-1:0] reg_rdata_i;

    modport master (
        output reg_addr_o,
        output reg_wdata_o,
        output reg_we_o,
        output reg_re_o,
        input  reg_rdata_i
    );

    modport slave (
        input  reg_addr_o,
        input  reg_wdata_o,
        input  reg_we_o,
        input  reg_re_o,
        output reg_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/spi_regif.sv
`default_nettype none
// ============================================================================
//  Module      : spi_regif
//  Description : SPI mode-0 slave bridging an external host to the register
//                file. Header = R/W bit (1 = write) + address, MSB first,
//                followed by any number of DATA_W-bit words. SCLK/CS/MOSI are
//                oversampled on clk_i. Optional abort reporting is compiled in
//                with the SPI_FRAME_ERR_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_regif #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AUTO_INC    = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sclk_i,
    input  logic             cs_i,
    input  logic             mosi_i,
    output logic             miso_o,
    spi_regif_if.master      bus,
    output logic             busy_o,
    output logic             frame_err_o
);

    // Shift register only needs the bits that precede the final one of a
    // header (ADDR_W) or of a data word (DATA_W-1).
    localparam int                c_SH_W      = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam int                c_CNT_W     = 6;
    localparam logic [c_CNT_W-1:0] c_HDR_LAST  = c_CNT_W'(ADDR_W);
    localparam logic [c_CNT_W-1:0] c_WORD_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_STEP = (AUTO_INC != 0) ? ADDR_W'(1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    // Chip select is synchronised in its active-high form so that a cleared
    // synchroniser reads as "inactive" and reset release never starts a frame.
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_act_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [c_SH_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_miso_sh;
    logic                   r_write;
    logic                   r_load_pending;
    logic                   r_inc_pending;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_we;
    logic                   r_re;

    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_act;
    logic                   w_mosi;
    logic [ADDR_W:0]        w_hdr;
    logic [DATA_W-1:0]      w_word;

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
    assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_act    = r_cs_act_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_hdr       = {r_shift[ADDR_W-1:0], w_mosi};
    assign w_word      = {r_shift[DATA_W-2:0], w_mosi};

    // Oversample the SPI pins through SYNC_STAGES-deep synchronisers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sclk_sync   <= '0;
            r_cs_act_sync <= '0;
            r_mosi_sync   <= '0;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_cs_act_sync <= {r_cs_act_sync[SYNC_STAGES-2:0], ~cs_i};
            r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
        end
    end

    // Frame state machine: header decode, word assembly, strobes and MISO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_miso_sh      <= '0;
            r_write        <= 1'b0;
            r_load_pending <= 1'b0;
            r_inc_pending  <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_we           <= 1'b0;
            r_re           <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_re <= 1'b0;

            // Post-write address step lands the cycle after the write strobe.
            if (r_inc_pending) begin
                r_addr        <= r_addr + c_ADDR_STEP;
                r_inc_pending <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt      <= '0;
                    r_shift        <= '0;
                    r_miso_sh      <= '0;
                    r_load_pending <= 1'b0;
                    if (w_cs_act) begin
                        r_state <= ST_HEADER;
                    end
                end

                ST_HEADER: begin
                    if (!w_cs_act) begin
                        r_state <= ST_IDLE;
                    end else if (w_sclk_rise) begin
                        if (r_bit_cnt == c_HDR_LAST) begin
                            r_write        <= w_hdr[ADDR_W];
                            r_addr         <= w_hdr[ADDR_W-1:0];
                            r_re           <= ~w_hdr[ADDR_W];
                            r_load_pending <= ~w_hdr[ADDR_W];
                            r_bit_cnt      <= '0;
                            r_state        <= ST_DATA;
                        end else begin
                            r_shift   <= {r_shift[c_SH_W-2:0], w_mosi};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (!w_cs_act) begin
                        // Partial word is dropped; address and write data hold.
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_sclk_rise) begin
                            if (r_bit_cnt == c_WORD_LAST) begin
                                r_bit_cnt <= '0;
                                if (r_write) begin
                                    r_wdata       <= w_word;
                                    r_we          <= 1'b1;
                                    r_inc_pending <= (AUTO_INC != 0);
                                end else begin
                                    // Prefetch the next word of the burst.
                                    r_addr         <= r_addr + c_ADDR_STEP;
                                    r_re           <= 1'b1;
                                    r_load_pending <= 1'b1;
                                end
                            end else begin
                                r_shift   <= {r_shift[c_SH_W-2:0], w_mosi};
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        if (w_sclk_fall && !r_write) begin
                            if (r_load_pending) begin
                                r_miso_sh      <= bus.reg_rdata_i;
                                r_load_pending <= 1'b0;
                            end else begin
                                r_miso_sh <= {r_miso_sh[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic r_frame_err;

    // Flag a frame that ends mid-header or mid-word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= !w_cs_act &&
                           ((r_state == ST_HEADER) ||
                            ((r_state == ST_DATA) && (r_bit_cnt != '0)));
        end
    end

    assign frame_err_o = r_frame_err;
`else
    assign frame_err_o = 1'b0;
`endif

    assign miso_o          = (r_state == ST_DATA) && !r_write && w_cs_act && r_miso_sh[DATA_W-1];
    assign busy_o          = (r_state != ST_IDLE);
    assign bus.reg_addr_o  = r_addr;
    assign bus.reg_wdata_o = r_wdata;
    assign bus.reg_we_o    = r_we;
    assign bus.reg_re_o    = r_re;

endmodule
`default_nettype wire
